// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and helpers for the I2S/TDM transmit master.
// Holds the FSM state enum, counter-width helper and parameter checks.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } i2s_state_e;

  // Width of a counter that spans 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_ok(
    input int data_w,
    input int slot_w,
    input int chans,
    input int depth,
    input int div
  );
    return data_w >= 2
        && slot_w >= data_w
        && chans >= 2
        && chans <= 8
        && (chans % 2) == 0
        && depth >= chans
        && (depth & (depth - 1)) == 0
        && div >= 1;
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: sync FIFO, DATA_W x DEPTH, first-word fall-through.
// Ports: wr_en/wr_data in, rd_en/rd_data out, level, full, empty.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = cnt_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Full is taken from the registered level, so a write is
  // refused when full even if a read happens in the same cycle.
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(wr_ok) - LW'(rd_ok);
    end
  end

endmodule

// File: rtl/i2s_tx_master.sv
// i2s_tx_master: I2S/TDM transmit master (SCK/WS gen, FIFO, serialiser).
// Ports: s_valid/s_ready/s_data in; sck, ws, sd, underrun, fifo_level.
// I2S_LEFT_JUSTIFIED_EN: define for left-justified (no one-SCK SD delay).
module i2s_tx_master
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  output logic                        sck,
  output logic                        ws,
  output logic                        sd,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = cnt_w(CLK_DIV);
  localparam int BW = cnt_w(SLOT_W);
  localparam int CW = cnt_w(CHANNELS);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_W - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(CHANNELS - 1);
  localparam logic [CW-1:0] SLOT_HALF = CW'(CHANNELS / 2);

  if (!params_ok(DATA_W, SLOT_W, CHANNELS,
                 FIFO_DEPTH, CLK_DIV)) begin : g_bad_cfg
    $error("i2s_tx_master: illegal parameter set");
  end

  i2s_state_e        state;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [CW-1:0]     slot_cnt;
  logic [CW-1:0]     slot_nx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] next_sh;
  logic              full;
  logic              empty;
  logic              pop;
  logic              start;
  logic              fall;
  logic              slot_end;
  logic              frame_end;
  logic              go_idle;
  logic              idle_hold;
  logic              running;
  logic              sd_first;
  logic              sd_next;

  i2s_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  assign s_ready = !full;

  assign start = state == IDLE && enable
              && fifo_level >= LW'(CHANNELS);

  // fall marks the clk cycle whose edge takes sck 1->0;
  // all bit/slot bookkeeping happens there.
  assign fall      = state != IDLE && sck
                  && div_cnt == DIV_LAST;
  assign slot_end  = bit_cnt == BIT_LAST;
  assign frame_end = slot_end && slot_cnt == SLOT_LAST;
  assign go_idle   = fall && frame_end && !enable;
  assign idle_hold = state == IDLE && !start;
  assign running   = state != IDLE && !go_idle;

  assign pop      = start || (fall && slot_end && !go_idle);
  // An empty pop sends silence but keeps slot alignment.
  assign load_val = empty ? '0 : rd_data;
  assign slot_nx  = frame_end ? '0 : slot_cnt + 1'b1;
  // Zero fill after DATA_W shifts pads the slot tail.
  assign next_sh  = slot_end ? load_val
                             : {shreg[DATA_W-2:0], 1'b0};

`ifdef I2S_LEFT_JUSTIFIED_EN
  assign sd_first = load_val[DATA_W-1];
  assign sd_next  = next_sh[DATA_W-1];
`else
  // The sd flop itself is the one-SCK delay stage.
  assign sd_first = 1'b0;
  assign sd_next  = shreg[DATA_W-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      slot_cnt <= '0;
      shreg    <= '0;
      sck      <= 1'b0;
      ws       <= 1'b0;
      sd       <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= pop && empty;
      unique case (1'b1)
        start: begin
          state    <= RUN;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          slot_cnt <= '0;
          shreg    <= load_val;
          sck      <= 1'b0;
          ws       <= 1'b0;
          sd       <= sd_first;
        end
        go_idle: begin
          state    <= IDLE;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          slot_cnt <= '0;
          shreg    <= '0;
          sck      <= 1'b0;
          ws       <= 1'b0;
          sd       <= 1'b0;
        end
        idle_hold: begin
          state <= IDLE;
        end
        running: begin
          state <= enable ? RUN : DRAIN;
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck     <= !sck;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (fall) begin
            sd    <= sd_next;
            shreg <= next_sh;
            if (slot_end) begin
              bit_cnt  <= '0;
              slot_cnt <= slot_nx;
              ws       <= slot_nx >= SLOT_HALF;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
